// File: rtl/bdb_ctrl_pkg.sv
// bdb_ctrl_pkg: shared state encoding and parameter defaults for the press controller
package bdb_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} bdb_state_e;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_COUNT_W = 8;
endpackage

// File: rtl/bdb_press_controller_if.sv
// bdb_press_controller_if: button inputs and debounced/count outputs of the press controller
interface bdb_press_controller_if #(
  parameter int COUNT_W = 8
);
  logic button;
  logic clear;
  logic enable;
  logic pressed;
  logic press_pulse;
  logic [COUNT_W-1:0] count;
  logic overflow;
  modport master(output button, clear, enable, input pressed, press_pulse, count, overflow);
  modport slave(input button, clear, enable, output pressed, press_pulse, count, overflow);
endinterface

// File: rtl/bdb_sync.sv
// bdb_sync: multi-flop synchronizer for an asynchronous level, cleared by active-low reset
module bdb_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clock)
    s <= !reset ? '0 : {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/bdb_press_controller.sv
// bdb_press_controller: debounces a button with a stability FSM and counts qualified presses
module bdb_press_controller
  import bdb_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input logic clock,
  input logic reset,
  bdb_press_controller_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  bdb_state_e state, state_n;
  logic [SW-1:0] stab, stab_n;
  logic btn_s, hit, pulse_n, pressed_q, pulse_q, overflow_q;
  logic [COUNT_W-1:0] count_q;
  bdb_sync #(.STAGES(SYNC_STAGES)) u_sync (.clock(clock), .reset(reset), .d(bus.button), .q(btn_s));
  assign hit = int'(stab) + 1 == STABLE_CYCLES;
  always_comb begin
    state_n = state;
    stab_n = stab;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = STABLE_CYCLES == 1 ? HELD : ARM_PRESS;
          stab_n = STABLE_CYCLES == 1 ? '0 : SW'(1);
        end else stab_n = '0;
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
          stab_n = '0;
        end else if (hit) begin
          state_n = HELD;
          stab_n = '0;
        end else stab_n = stab + SW'(1);
      end
      HELD: begin
        if (!btn_s) begin
          state_n = STABLE_CYCLES == 1 ? IDLE : ARM_RELEASE;
          stab_n = STABLE_CYCLES == 1 ? '0 : SW'(1);
        end
      end
      default: begin
        if (btn_s) begin
          state_n = HELD;
          stab_n = '0;
        end else if (hit) begin
          state_n = IDLE;
          stab_n = '0;
        end else stab_n = stab + SW'(1);
      end
    endcase
  end
  // Only an entry from the press side counts; bouncing back from ARM_RELEASE does not
  assign pulse_n = state_n == HELD && (state == IDLE || state == ARM_PRESS);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      stab <= '0;
      pressed_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_n;
      stab <= stab_n;
      pressed_q <= state_n == HELD || state_n == ARM_RELEASE;
      pulse_q <= pulse_n;
      if (bus.clear) begin
        count_q <= '0;
        overflow_q <= 1'b0;
      end else if (pulse_n && bus.enable) begin
        count_q <= count_q + COUNT_W'(1);
        if (&count_q) overflow_q <= 1'b1;
      end
    end
  end
  assign bus.pressed = pressed_q;
  assign bus.press_pulse = pulse_q;
  assign bus.count = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bdb_press_controller.sv
// tb_bdb_press_controller: scoreboard bench; expected pulses are queued at stimulus time and checked by a monitor
module tb_bdb_press_controller;
  typedef struct {
    int cyc;
    int count;
    int ovf;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  bdb_press_controller_if #(.COUNT_W(4)) bus ();
  bdb_press_controller #(.COUNT_W(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic expect_pulse(input int lat, input int cnt, input int ovf);
    exp_t e;
    e.cyc = cyc + lat;
    e.count = cnt;
    e.ovf = ovf;
    sb.push_back(e);
  endtask
  task automatic press(input int cnt, input int ovf);
    bus.button = 1'b1;
    expect_pulse(6, cnt, ovf);
    tick(20);
    bus.button = 1'b0;
    tick(10);
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (bus.press_pulse) begin
      if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_count", int'(bus.count), e.count);
        chk("pulse_overflow", int'(bus.overflow), e.ovf);
        chk("pulse_pressed", int'(bus.pressed), 1);
      end
    end
  end
  initial begin
    bus.button = 1'b0;
    bus.clear = 1'b0;
    bus.enable = 1'b1;
    tick(2);
    chk("rst_pressed", int'(bus.pressed), 0);
    chk("rst_pulse", int'(bus.press_pulse), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    bus.button = 1'b1;
    expect_pulse(6, 1, 0);
    tick(20);
    chk("held_pressed", int'(bus.pressed), 1);
    chk("held_count", int'(bus.count), 1);
    chk("held_overflow", int'(bus.overflow), 0);
    bus.button = 1'b0;
    tick(10);
    chk("released_pressed", int'(bus.pressed), 0);
    for (int i = 0; i < 4; i++) begin
      bus.button = i % 2 == 0;
      tick(1);
    end
    bus.button = 1'b1;
    expect_pulse(6, 2, 0);
    tick(20);
    bus.button = 1'b0;
    tick(2);
    bus.button = 1'b1;
    tick(1);
    bus.button = 1'b0;
    tick(5);
    chk("rel_bounce_pressed", int'(bus.pressed), 1);
    tick(1);
    chk("rel_done_pressed", int'(bus.pressed), 0);
    chk("rel_count", int'(bus.count), 2);
    tick(10);
    for (int i = 3; i <= 16; i++) press(i % 16, int'(i == 16));
    chk("wrap_count", int'(bus.count), 0);
    chk("wrap_overflow_sticky", int'(bus.overflow), 1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clear_count", int'(bus.count), 0);
    chk("clear_overflow", int'(bus.overflow), 0);
    for (int i = 1; i <= 7; i++) press(i, 0);
    chk("pre_clear_count", int'(bus.count), 7);
    bus.button = 1'b1;
    expect_pulse(6, 0, 0);
    tick(5);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(14);
    bus.button = 1'b0;
    tick(10);
    chk("clear_beats_inc", int'(bus.count), 0);
    press(1, 0);
    bus.enable = 1'b0;
    press(1, 0);
    chk("disabled_count", int'(bus.count), 1);
    bus.enable = 1'b1;
    bus.button = 1'b1;
    expect_pulse(6, 2, 0);
    tick(10);
    chk("pre_reset_pressed", int'(bus.pressed), 1);
    reset = 1'b0;
    expect_pulse(7, 1, 0);
    tick(1);
    chk("midrst_pressed", int'(bus.pressed), 0);
    chk("midrst_pulse", int'(bus.press_pulse), 0);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    tick(20);
    chk("requal_count", int'(bus.count), 1);
    bus.button = 1'b0;
    tick(10);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bdb_press_controller.md
Name: bdb_press_controller

Overview:
Sequencing controller for the debounced-counter datapath.
- Synchronizes the raw button input.
- Qualifies presses and releases with a stability FSM.
- Issues exactly one single-cycle increment per qualified press to a wrapping press counter.
- Sits between the board button pin (or the bench driver's button signal) and the count display/readout logic.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized samples required to accept a press or a release (legal 1..255)
SYNC_STAGES, 2, flops in the button synchronizer (legal 2..4)
COUNT_W, 8, width of press counter

Ports:
clock  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clock
button  in  1  raw, asynchronous, bouncing push-button level
clear  in  1  synchronous clear of count and overflow
enable  in  1  when 0, qualified presses are tracked but not counted
pressed  out  1  debounced button level
press_pulse  out  1  one-cycle strobe per qualified press
count  out  COUNT_W  number of counted presses, wraps
overflow  out  1  sticky; set when count wraps from all-ones to 0

Behaviour:
- Reset (reset=0 at a rising edge): all of the following clear to 0 on that edge and hold while reset=0:
  - sync flops, stability counter, count, press_pulse, overflow, pressed
  - state = IDLE
- btn_s: output of the SYNC_STAGES-deep synchronizer. It lags button by SYNC_STAGES edges. The FSM uses only btn_s.
- Stability counter: width ceil(log2(STABLE_CYCLES+1)); it never exceeds STABLE_CYCLES.
- FSM states: IDLE, ARM_PRESS, HELD, ARM_RELEASE.
  - IDLE: btn_s=1 -> ARM_PRESS, stab=1. Otherwise stay, stab=0.
  - ARM_PRESS:
    - btn_s=0 -> IDLE, stab=0 (glitch rejected).
    - btn_s=1 and stab+1==STABLE_CYCLES -> HELD.
    - Otherwise stab++.
    - With STABLE_CYCLES=1, IDLE goes directly to HELD on the first btn_s=1 sample (ARM_PRESS is skipped).
  - HELD: btn_s=0 -> ARM_RELEASE, stab=1. Otherwise stay.
  - ARM_RELEASE:
    - btn_s=1 -> HELD, stab=0 (release bounce; no new pulse).
    - btn_s=0 and stab+1==STABLE_CYCLES -> IDLE.
    - Otherwise stab++.
    - With STABLE_CYCLES=1, HELD goes directly to IDLE.
- pressed: registered; equals 1 exactly while state is HELD or ARM_RELEASE.
- press_pulse: registered; high for exactly the one cycle in which state first becomes HELD from IDLE/ARM_PRESS. Never high on an ARM_RELEASE->HELD return.
- Latency: with button held clean from the edge where it is first sampled high (edge 0), press_pulse and pressed rise after edge SYNC_STAGES+STABLE_CYCLES-1. Defaults: edge 5, i.e. visible in the 6th cycle.
- Counting: on the edge where press_pulse is set, if enable=1 the count increments on the same edge (modulo 2^COUNT_W). The count and press_pulse change together.
- Wrap: count all-ones plus an increment -> count=0 and overflow=1. overflow stays 1 until clear or reset.
- clear=1: count=0 and overflow=0 on that edge. clear beats a simultaneous increment; press_pulse is still emitted. clear does not affect the FSM.
- enable=0: the FSM, pressed and press_pulse behave normally; count is held.
- Reset mid-press: the state is lost. A button still held after reset release is re-qualified from IDLE and counted once.
- A continuously held button produces only one pulse, with no auto-repeat.

Decomposition:
- Package bdb_ctrl_pkg contains:
  - typedef enum logic [1:0] bdb_state_e {IDLE, ARM_PRESS, HELD, ARM_RELEASE}
  - localparam defaults for STABLE_CYCLES, SYNC_STAGES and COUNT_W
- Sub-module bdb_sync: a parameterized SYNC_STAGES flop chain with synchronous active-low reset to 0.
- FSM, stability counter and press counter live in the top module.

Test Plan:
- Reset asserted 2 cycles, then button held high 20 cycles with defaults -> press_pulse single high cycle after edge 5; pressed=1; count=1; overflow=0.
- Button bounces 1,0,1,0 (one cycle each), then steady high -> no pulse during the bounce; exactly one pulse 6 edges after the steady high begins; count=1.
- Press qualified, then a release bounce (btn 0 for 2 cycles, 1, then 0 steady) -> pressed stays 1 through the bounce, drops after 4 stable low samples; count unchanged at 1.
- COUNT_W=4: 16 clean press/release cycles -> count 15->0 on the 16th press, overflow=1. Then clear=1 -> count=0, overflow=0.
- clear asserted on the same edge as a qualified press (count=7) -> count=0, press_pulse=1. enable=0 press -> press_pulse=1, count unchanged.
- Button held, reset pulsed low for 1 cycle while in HELD -> all outputs 0 next cycle; one new press_pulse after 6 edges; count=1.
